// File: rtl/aes_round_ctrl_if.sv
// Interface bundle for the AES round controller.
//
// Groups the request handshake, key-expansion handshake, datapath controls and
// result handshake into one interface.
//   master : the controller's view. It drives in_ready, kx_start, dp_*, rk_idx,
//            out_valid, out_err and busy.
//   slave  : the surrounding system's view. It drives in_valid, in_nk, in_dec,
//            in_key_new, kx_done and out_ready.
interface aes_round_ctrl_if;

  // Request side
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_nk;
  logic       in_dec;
  logic       in_key_new;

  // Key-expansion unit handshake
  logic       kx_start;
  logic       kx_done;

  // Datapath controls
  logic       dp_load;
  logic       dp_round;
  logic       dp_last;
  logic       dp_dec;
  logic [3:0] rk_idx;

  // Result side
  logic       out_valid;
  logic       out_ready;
  logic       out_err;
  logic       busy;

  modport master (
    input  in_valid,
    input  in_nk,
    input  in_dec,
    input  in_key_new,
    input  kx_done,
    input  out_ready,
    output in_ready,
    output kx_start,
    output dp_load,
    output dp_round,
    output dp_last,
    output dp_dec,
    output rk_idx,
    output out_valid,
    output out_err,
    output busy
  );

  modport slave (
    output in_valid,
    output in_nk,
    output in_dec,
    output in_key_new,
    output kx_done,
    output out_ready,
    input  in_ready,
    input  kx_start,
    input  dp_load,
    input  dp_round,
    input  dp_last,
    input  dp_dec,
    input  rk_idx,
    input  out_valid,
    input  out_err,
    input  busy
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// AES round controller.
//
// Accepts one encrypt/decrypt request at a time, optionally kicks the external
// key-expansion unit, then sequences the datapath through the initial
// AddRoundKey (LOAD) and Nr = Nk + 6 rounds, presenting the round-key index for
// each step. The result is held in DONE until the consumer accepts it.
//
// A small key cache {kvalid, knk} remembers the key length of the last
// completed expansion so that back-to-back requests with an unchanged key skip
// the expansion step.
//
// Ports:
//   clk  : single clock, rising edge.
//   rst  : asynchronous active-high reset; forces every output to 0.
//   bus  : aes_round_ctrl_if.master -- request, key-expansion, datapath and
//          result signals (see the interface file for the signal list).
module aes_round_ctrl (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StKexp  = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StRound = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] nk_q, nk_d;       // latched key length of the current request
  logic       dec_q, dec_d;     // latched direction
  logic       err_q, err_d;     // current request had an illegal key length
  logic [3:0] rnd_q, rnd_d;     // round counter, 1..Nr while in ROUND
  logic       kvalid_q, kvalid_d;
  logic [3:0] knk_q, knk_d;     // key length of the cached schedule
  logic       kx_first_q, kx_first_d;

  logic       accept;
  logic       nk_legal;
  logic       need_kexp;
  logic [3:0] nr;

  // Nr is derived from the latched Nk; only meaningful for legal Nk (max 14).
  assign nr = nk_q + 4'd6;

  assign bus.in_ready = (state_q == StIdle) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  assign nk_legal  = (bus.in_nk == 4'd4) || (bus.in_nk == 4'd6) || (bus.in_nk == 4'd8);
  assign need_kexp = bus.in_key_new || !kvalid_q || (knk_q != bus.in_nk);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    nk_d       = nk_q;
    dec_d      = dec_q;
    err_d      = err_q;
    rnd_d      = rnd_q;
    kvalid_d   = kvalid_q;
    knk_d      = knk_q;
    kx_first_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          nk_d  = bus.in_nk;
          dec_d = bus.in_dec;
          err_d = 1'b0;
          if (!nk_legal) begin
            // Illegal length: report straight away, leave the cache alone.
            err_d   = 1'b1;
            state_d = StDone;
          end else if (need_kexp) begin
            state_d    = StKexp;
            kx_first_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StKexp: begin
        // kx_done is honoured on every KEXP cycle, including the kx_start one.
        if (bus.kx_done) begin
          kvalid_d = 1'b1;
          knk_d    = nk_q;
          state_d  = StLoad;
        end
      end

      StLoad: begin
        rnd_d   = 4'd1;
        state_d = StRound;
      end

      StRound: begin
        if (rnd_q == nr) begin
          rnd_d   = 4'd0;
          state_d = StDone;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        rnd_d   = 4'd0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      nk_q       <= 4'd0;
      dec_q      <= 1'b0;
      err_q      <= 1'b0;
      rnd_q      <= 4'd0;
      kvalid_q   <= 1'b0;
      knk_q      <= 4'd0;
      kx_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      dec_q      <= dec_d;
      err_q      <= err_d;
      rnd_q      <= rnd_d;
      kvalid_q   <= kvalid_d;
      knk_q      <= knk_d;
      kx_first_q <= kx_first_d;
    end
  end

  // Outputs are decoded from the registered state only, so reset clears them
  // immediately through the asynchronous flop reset.
  always_comb begin
    bus.kx_start  = 1'b0;
    bus.dp_load   = 1'b0;
    bus.dp_round  = 1'b0;
    bus.dp_last   = 1'b0;
    bus.rk_idx    = 4'd0;
    bus.out_valid = 1'b0;
    bus.out_err   = 1'b0;

    case (state_q)
      StKexp: begin
        bus.kx_start = kx_first_q;
      end
      StLoad: begin
        bus.dp_load = 1'b1;
        bus.rk_idx  = dec_q ? nr : 4'd0;
      end
      StRound: begin
        bus.dp_round = 1'b1;
        bus.dp_last  = (rnd_q == nr);
        // Decryption walks the schedule backwards.
        bus.rk_idx   = dec_q ? (nr - rnd_q) : rnd_q;
      end
      StDone: begin
        bus.out_valid = 1'b1;
        bus.out_err   = err_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.dp_dec = bus.busy && dec_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();

  aes_round_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle behaviour plus the stimulus the model wants driven.
  typedef struct packed {
    logic       in_ready;
    logic       busy;
    logic       kx_start;
    logic       dp_load;
    logic       dp_round;
    logic       dp_last;
    logic       dp_dec;
    logic [3:0] rk_idx;
    logic       out_valid;
    logic       out_err;
    logic       is_kexp;
    logic       drv_kx_done;
    logic       drv_out_ready;
  } cyc_t;

  typedef struct {
    logic [3:0] nk;
    logic       dec;
    logic       key_new;
    int         kx_dly;
    int         rdy_dly;
    bit         hold;
    int         exp_kx;
    int         exp_lat;
    int         exp_rounds;
    int         exp_last_rk;
    int         exp_err;
  } vec_t;

  cyc_t exp_q[$];
  vec_t vecs[12];

  // Reference key cache
  bit         m_kvalid;
  logic [3:0] m_knk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [12:0] pack_dut();
    return {bus.in_ready, bus.busy, bus.kx_start, bus.dp_load, bus.dp_round, bus.dp_last,
            bus.dp_dec, bus.rk_idx, bus.out_valid, bus.out_err};
  endfunction

  function automatic logic [12:0] pack_exp(input cyc_t e);
    return {e.in_ready, e.busy, e.kx_start, e.dp_load, e.dp_round, e.dp_last,
            e.dp_dec, e.rk_idx, e.out_valid, e.out_err};
  endfunction

  function automatic cyc_t busy_base(input logic dec);
    cyc_t c;
    c        = '0;
    c.busy   = 1'b1;
    c.dp_dec = dec;
    return c;
  endfunction

  // Builds the full expected trace (cycles 1..end) of one request from the
  // rules: optional expansion, one load, Nr rounds, then the result hold.
  task automatic build_model(input logic [3:0] nk, input logic dec, input logic kn,
                             input int kx_dly, input int rdy_dly);
    cyc_t c;
    int   nr;
    bit   legal;
    exp_q.delete();
    legal = (nk == 4'd4) || (nk == 4'd6) || (nk == 4'd8);
    nr    = int'(nk) + 6;
    if (legal) begin
      if (kn || !m_kvalid || m_knk != nk) begin
        for (int i = 0; i <= kx_dly; i++) begin
          c             = busy_base(dec);
          c.kx_start    = (i == 0);
          c.is_kexp     = 1'b1;
          c.drv_kx_done = (i == kx_dly);
          exp_q.push_back(c);
        end
        m_kvalid = 1'b1;
        m_knk    = nk;
      end
      c         = busy_base(dec);
      c.dp_load = 1'b1;
      c.rk_idx  = 4'(dec ? nr : 0);
      exp_q.push_back(c);
      for (int r = 1; r <= nr; r++) begin
        c          = busy_base(dec);
        c.dp_round = 1'b1;
        c.rk_idx   = 4'(dec ? nr - r : r);
        c.dp_last  = (r == nr);
        exp_q.push_back(c);
      end
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      c               = busy_base(dec);
      c.out_valid     = 1'b1;
      c.out_err       = !legal;
      c.drv_out_ready = (i == rdy_dly);
      exp_q.push_back(c);
    end
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_req(input string name, input logic [3:0] nk, input logic dec,
                         input logic kn, input int kx_dly, input int rdy_dly,
                         input bit hold, input bit noise,
                         output int n_kx, output int lat, output int n_rounds,
                         output int last_rk, output int err);
    cyc_t idle_e;
    cyc_t e;
    build_model(nk, dec, kn, kx_dly, rdy_dly);
    n_kx = 0; lat = 0; n_rounds = 0; last_rk = 0; err = 0;
    idle_e          = '0;
    idle_e.in_ready = 1'b1;
    check({name, "_idle"}, 32'(pack_dut()), 32'(pack_exp(idle_e)));
    bus.in_valid   = 1'b1;
    bus.in_nk      = nk;
    bus.in_dec     = dec;
    bus.in_key_new = kn;
    bus.out_ready  = noise ? 1'($urandom % 2) : 1'b0;
    bus.kx_done    = noise ? 1'($urandom % 2) : 1'b0;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      e = exp_q[c-1];
      check($sformatf("%s_c%0d", name, c), 32'(pack_dut()), 32'(pack_exp(e)));
      n_kx     += int'(bus.kx_start);
      n_rounds += int'(bus.dp_round);
      if (bus.dp_last) last_rk = int'(bus.rk_idx);
      if (bus.out_valid && lat == 0) begin
        lat = c;
        err = int'(bus.out_err);
      end
      if (hold) begin
        bus.in_valid   = 1'b1;
        bus.in_nk      = 4'($urandom % 16);
        bus.in_dec     = 1'($urandom % 2);
        bus.in_key_new = 1'($urandom % 2);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.kx_done   = e.is_kexp ? e.drv_kx_done : (noise ? 1'($urandom % 2) : 1'b0);
      bus.out_ready = e.out_valid ? e.drv_out_ready : (noise ? 1'($urandom % 2) : 1'b0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.kx_done   = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int n_kx, lat, n_rounds, last_rk, err;
    int saw_ov;
    logic [3:0] nk;

    //            nk    dec   kn    kx rdy hold  kx lat rnd last err
    vecs[0]  = '{4'd4, 1'b0, 1'b0, 2, 0, 1'b0, 1, 15, 10, 10, 0};
    vecs[1]  = '{4'd4, 1'b1, 1'b0, 0, 0, 1'b0, 0, 12, 10, 0,  0};
    vecs[2]  = '{4'd8, 1'b0, 1'b0, 0, 0, 1'b0, 1, 17, 14, 14, 0};
    vecs[3]  = '{4'd5, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1,  0,  0,  1};
    vecs[4]  = '{4'd8, 1'b0, 1'b0, 0, 0, 1'b0, 0, 16, 14, 14, 0};
    vecs[5]  = '{4'd6, 1'b1, 1'b0, 4, 0, 1'b0, 1, 19, 12, 0,  0};
    vecs[6]  = '{4'd6, 1'b1, 1'b1, 1, 1, 1'b0, 1, 16, 12, 0,  0};
    vecs[7]  = '{4'd6, 1'b0, 1'b0, 0, 5, 1'b1, 0, 14, 12, 12, 0};
    vecs[8]  = '{4'd4, 1'b0, 1'b0, 0, 0, 1'b0, 1, 13, 10, 10, 0};
    vecs[9]  = '{4'd0, 1'b0, 1'b0, 0, 2, 1'b0, 0, 1,  0,  0,  1};
    vecs[10] = '{4'd15, 1'b1, 1'b1, 0, 0, 1'b0, 0, 1, 0,  0,  1};
    vecs[11] = '{4'd4, 1'b1, 1'b0, 0, 0, 1'b0, 0, 12, 10, 0,  0};

    m_kvalid       = 1'b0;
    m_knk          = 4'd0;
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_nk      = 4'd4;
    bus.in_dec     = 1'b1;
    bus.in_key_new = 1'b0;
    bus.kx_done    = 1'b1;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(pack_dut()), 32'd0);
    bus.in_valid  = 1'b0;
    bus.kx_done   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].nk, vecs[i].dec, vecs[i].key_new,
              vecs[i].kx_dly, vecs[i].rdy_dly, vecs[i].hold, 1'b0,
              n_kx, lat, n_rounds, last_rk, err);
      check($sformatf("vec%0d_kx", i),     n_kx,     vecs[i].exp_kx);
      check($sformatf("vec%0d_lat", i),    lat,      vecs[i].exp_lat);
      check($sformatf("vec%0d_rounds", i), n_rounds, vecs[i].exp_rounds);
      check($sformatf("vec%0d_lastrk", i), last_rk,  vecs[i].exp_last_rk);
      check($sformatf("vec%0d_err", i),    err,      vecs[i].exp_err);
    end

    // Reset in the middle of ROUND at r=5
    bus.in_valid   = 1'b1;
    bus.in_nk      = 4'd4;
    bus.in_dec     = 1'b0;
    bus.in_key_new = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.kx_done  = 1'b1;
    for (int i = 0; i < 40 && !(bus.dp_round && bus.rk_idx == 4'd5); i++) @(negedge clk);
    check("reach_r5", 32'(bus.dp_round && bus.rk_idx == 4'd5), 32'd1);
    bus.kx_done = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async", 32'(pack_dut()), 32'd0);
    @(negedge clk);
    check("rst_held", 32'(pack_dut()), 32'd0);
    rst      = 1'b0;
    m_kvalid = 1'b0;
    m_knk    = 4'd0;
    saw_ov   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      saw_ov += int'(bus.out_valid);
    end
    check("rst_no_out_valid", saw_ov, 0);
    run_req("post_rst", 4'd4, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, n_kx, lat, n_rounds, last_rk, err);
    check("post_rst_kx", n_kx, 1);
    check("post_rst_lat", lat, 14);

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom % 8 < 6) begin
        case ($urandom % 3)
          0:       nk = 4'd4;
          1:       nk = 4'd6;
          default: nk = 4'd8;
        endcase
      end else begin
        do nk = 4'($urandom % 16); while (nk == 4'd4 || nk == 4'd6 || nk == 4'd8);
      end
      run_req($sformatf("rnd%0d", i), nk, 1'($urandom % 2), 1'($urandom % 4 == 0),
              int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2), 1'b1,
              n_kx, lat, n_rounds, last_rk, err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
